// File: rtl/ladner_fischer_approx_k8_pkg.sv
// Shared defaults and helpers for the approximate Ladner-Fischer adder.
package ladner_fischer_approx_k8_pkg;

  localparam int LF_WIDTH = 16;
  localparam int LF_K     = 8;

  // Number of prefix levels needed to span n bits: ceil(log2(n)).
  function automatic int lf_levels(input int n);
    int l;
    l = 0;
    while ((1 << l) < n) l++;
    return l;
  endfunction

endpackage

// File: rtl/ladner_fischer_approx_k8_lf_prefix_network.sv
// Ladner-Fischer parallel-prefix carry network with an external carry-in.
module lf_prefix_network
  import ladner_fischer_approx_k8_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] i_g,
  input  logic [N-1:0] i_p,
  input  logic         i_cin,
  output logic [N-1:0] o_carry
);

  localparam int LV = lf_levels(N);

  logic [N-1:0] w_gg [0:LV];
  logic [N-1:0] w_pp [0:LV];

  assign w_gg[0] = i_g;
  assign w_pp[0] = i_p;

  // Each bit with bit l of its index set merges with the top of the lower half-block.
  // Group propagate is kept everywhere so the carry-in can be folded in at the end.
  for (genvar l = 0; l < LV; l++) begin : g_level
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i >> l) & 1) == 1) begin : g_cell
        localparam int J = ((i >> l) << l) - 1;
        assign w_gg[l+1][i] = w_gg[l][i] | (w_pp[l][i] & w_gg[l][J]);
        assign w_pp[l+1][i] = w_pp[l][i] & w_pp[l][J];
      end else begin : g_pass
        assign w_gg[l+1][i] = w_gg[l][i];
        assign w_pp[l+1][i] = w_pp[l][i];
      end
    end
  end

  assign o_carry = w_gg[LV] | (w_pp[LV] & {N{i_cin}});

endmodule

// File: rtl/ladner_fischer_approx_k8.sv
// Registered approximate adder: OR-based low K bits, exact prefix adder above,
// with the upper part seeded by the generate bit of bit K.
module ladner_fischer_approx_k8
  import ladner_fischer_approx_k8_pkg::*;
#(
  parameter int WIDTH = LF_WIDTH,
  parameter int K     = LF_K
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:1]   A,
  input  logic [WIDTH:1]   B,
  input  logic             Cin,
  output logic [WIDTH:0]   Cout,
  output logic [WIDTH+1:1] Sum
);

  logic [WIDTH:1]   w_g;
  logic [WIDTH:0]   w_cout;
  logic [WIDTH+1:1] w_sum;
  logic             w_seed;

  assign w_g       = A & B;
  assign w_cout[0] = Cin;

  if (K >= 1) begin : g_approx
    assign w_sum[K:1]  = A[K:1] | B[K:1];
    assign w_cout[K:1] = w_g[K:1];
    assign w_seed      = w_g[K];
  end else begin : g_no_approx
    assign w_seed = Cin;
  end

  if (K < WIDTH) begin : g_exact
    lf_prefix_network #(
      .N (WIDTH - K)
    ) u_prefix (
      .i_g     (w_g[WIDTH:K+1]),
      .i_p     (A[WIDTH:K+1] ^ B[WIDTH:K+1]),
      .i_cin   (w_seed),
      .o_carry (w_cout[WIDTH:K+1])
    );
    assign w_sum[WIDTH:K+1] = (A[WIDTH:K+1] ^ B[WIDTH:K+1]) ^ w_cout[WIDTH-1:K];
  end

  assign w_sum[WIDTH+1] = w_cout[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Cout <= '0;
      Sum  <= '0;
    end else begin
      Cout <= w_cout;
      Sum  <= w_sum;
    end
  end

endmodule

// File: tb/tb_ladner_fischer_approx_k8.sv
// Scoreboard bench: three builds (K=0, 8, 16) driven in parallel and compared
// against an arithmetic reference of the approximate-adder rules.
module tb_ladner_fischer_approx_k8;

  typedef struct {
    logic [16:0] sum;
    logic [16:0] cout;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [16:1] A;
  logic [16:1] B;
  logic        Cin;
  logic [16:0] cout0, cout8, cout16;
  logic [17:1] sum0, sum8, sum16;

  exp_t q0[$];
  exp_t q8[$];
  exp_t q16[$];

  int n_checks;
  int n_err;

  ladner_fischer_approx_k8 #(.WIDTH(16), .K(0)) u_k0 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Cout(cout0), .Sum(sum0)
  );
  ladner_fischer_approx_k8 #(.WIDTH(16), .K(8)) u_k8 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Cout(cout8), .Sum(sum8)
  );
  ladner_fischer_approx_k8 #(.WIDTH(16), .K(16)) u_k16 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin), .Cout(cout16), .Sum(sum16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Low k bits: OR, carries = generate bits. Upper bits: plain addition of the
  // upper operand slices plus the seed carry (g of bit k, or Cin when k=0).
  function automatic void model(input int k, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, output logic [16:0] s, output logic [16:0] c);
    int ai, bi, lo_mask, aup, bup, seed, up, m;
    ai      = int'(a);
    bi      = int'(b);
    lo_mask = (1 << k) - 1;
    seed    = (k > 0) ? int'(a[k-1] & b[k-1]) : int'(cin);
    aup     = ai >> k;
    bup     = bi >> k;
    up      = aup + bup + seed;
    s       = 17'((up << k) | ((ai | bi) & lo_mask));
    c       = '0;
    c[0]    = cin;
    for (int i = 1; i <= k; i++) c[i] = a[i-1] & b[i-1];
    for (int j = 1; j <= 16 - k; j++) begin
      m        = (1 << j) - 1;
      c[k + j] = 1'((((aup & m) + (bup & m) + seed) >> j) & 1);
    end
  endfunction

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input string tag, input bit f8, input logic [16:0] s8,
                          input bit f0, input logic [16:0] s0);
    exp_t e;
    e.tag = tag;
    model(0, a, b, c, e.sum, e.cout);
    if (f0) e.sum = s0;
    q0.push_back(e);
    model(8, a, b, c, e.sum, e.cout);
    if (f8) e.sum = s8;
    q8.push_back(e);
    model(16, a, b, c, e.sum, e.cout);
    q16.push_back(e);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input string tag, input bit f8 = 1'b0, input logic [16:0] s8 = '0,
                       input bit f0 = 1'b0, input logic [16:0] s0 = '0);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = c;
    push_exp(a, b, c, tag, f8, s8, f0, s0);
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk({e.tag, " k0 sum"}, sum0, e.sum);
      chk({e.tag, " k0 cout"}, cout0, e.cout);
    end
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk({e.tag, " k8 sum"}, sum8, e.sum);
      chk({e.tag, " k8 cout"}, cout8, e.cout);
    end
    if (q16.size() > 0) begin
      e = q16.pop_front();
      chk({e.tag, " k16 sum"}, sum16, e.sum);
      chk({e.tag, " k16 cout"}, cout16, e.cout);
    end
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    A        = '0;
    B        = '0;
    Cin      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset k8 sum", sum8, '0);
    chk("reset k8 cout", cout8, '0);
    @(negedge clk);
    rst = 1'b0;

    issue(16'hAAAA, 16'hCCCC, 1'b0, "aa_cc", 1'b1, 17'h177EE);
    issue(16'hFFFF, 16'h0000, 1'b0, "ff_00", 1'b1, 17'h0FFFF);
    issue(16'h0000, 16'hFFFF, 1'b1, "00_ff_cin", 1'b1, 17'h0FFFF);
    issue(16'h5555, 16'hAAAA, 1'b1, "55_aa_cin", 1'b1, 17'h0FFFF);
    issue(16'h0080, 16'h0080, 1'b0, "spec_carry", 1'b1, 17'h00180);
    issue(16'hFFFF, 16'h0001, 1'b0, "exact_k0", 1'b0, '0, 1'b1, 17'h10000);
    issue(16'hAAAA, 16'hCCCC, 1'b1, "pre_reset");

    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async reset k8 sum", sum8, '0);
    chk("async reset k8 cout", cout8, '0);
    chk("async reset k16 sum", sum16, '0);
    @(negedge clk);
    A   = 16'hFFFF;
    B   = 16'h8181;
    Cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hold k8 sum", sum8, '0);
    chk("reset hold k0 cout", cout0, '0);
    @(negedge clk);
    rst = 1'b0;
    push_exp(16'hFFFF, 16'h8181, 1'b1, "post_reset", 1'b0, '0, 1'b0, '0);
    #1;
    chk("deassert k8 sum", sum8, '0);
    chk("deassert k0 sum", sum0, '0);

    for (int n = 0; n < 400; n++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom), "rand");
    end

    for (int i = 0; i < 10 && (q0.size() + q8.size() + q16.size()) > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if ((q0.size() + q8.size() + q16.size()) != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending results expected 0", q0.size() + q8.size() + q16.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ladner_fischer_approx_k8.md
Name: ladner_fischer_approx_k8

Overview:
- Registered approximate adder for error-tolerant datapaths, built on a Ladner-Fischer parallel-prefix structure.
- The low K bits use a carry-free OR approximation.
- The high WIDTH-K bits are an exact Ladner-Fischer prefix adder.
- The upper part is seeded by a speculative carry taken from bit K.

Parameters:
- WIDTH, 16, operand width in bits. Bits are indexed 1..WIDTH, with bit 1 as the LSB.
- K, 8, number of approximated low bits. Legal range 0..WIDTH; K=0 gives an exact adder.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  [WIDTH:1]  operand A
- B  input  [WIDTH:1]  operand B
- Cin  input  1  carry-in
- Cout  output  [WIDTH:0]  registered per-bit carry vector. Cout[0] is Cin; Cout[i] is the carry out of bit i.
- Sum  output  [WIDTH+1:1]  registered sum. Sum[WIDTH+1] equals Cout[WIDTH].

Behaviour:
- Timing:
  - A, B and Cin are sampled combinationally; the computed result is captured on the rising edge of clk.
  - Latency is 1 cycle, with a new result every cycle and no handshake.
- Reset:
  - rst=1 clears Sum and Cout to all zeros immediately (asynchronous) and holds them there while asserted.
  - The first valid result appears on the first rising edge after rst deasserts.
- Per-bit signals: g[i]=A[i]&B[i], p[i]=A[i]^B[i].
- Approximate region, i in 1..K:
  - Sum[i] = A[i] | B[i].
  - Cout[i] = g[i].
  - Cin affects only Cout[0] when K≥1.
- Seed carry: c[K] = g[K] if K≥1, else Cin.
- Exact region, i in K+1..WIDTH:
  - Ladner-Fischer prefix tree of (G,P) black and grey cells over bits K+1..WIDTH, ceil(log2(WIDTH-K)) levels, with c[K] as carry-in.
  - Cout[i] = G[i:K+1] | (P[i:K+1] & c[K]).
  - Sum[i] = p[i] ^ Cout[i-1].
- Upper bits: Cout[0]=Cin; Sum[WIDTH+1]=Cout[WIDTH].
- K=WIDTH: the whole sum is OR-based, and Sum[WIDTH+1]=g[WIDTH].
- No overflow flag; the result is always WIDTH+1 bits.
- Error model:
  - The result is never greater than A+B+Cin plus 2^K.
  - Errors arise only from carries lost or mis-predicted inside the low K bits. This is an intended property; benches compare against the exact formula above, not against the exact sum.

Decomposition:
- Shared package: default WIDTH and K constants, and a function computing the number of prefix levels (clog2).
- One sub-module, lf_prefix_network:
  - Parameterised width.
  - Takes g/p vectors and a carry-in; returns the carry vector.
  - Used for the exact upper region.
- The top level contains the OR-approximation logic, the seed carry and the output registers.

Test Plan:
- Reset: assert rst mid-stream with nonzero outputs → Sum=0 and Cout=0 immediately; outputs stay zero until after deassert plus one edge.
- A=0xAAAA, B=0xCCCC, Cin=0 → after 1 cycle Sum=0x177EE (exact value would be 0x17776), Cout[16]=1.
- A=0xFFFF, B=0x0000, Cin=0 → Sum=0x0FFFF, Cout=0.
- A=0x0000, B=0xFFFF, Cin=1 → Sum=0x0FFFF (Cin is dropped by the approximation), Cout[0]=1, Cout[16:1]=0.
- A=0x5555, B=0xAAAA, Cin=1 → Sum=0x0FFFF. Then A=0x0080, B=0x0080, Cin=0 → Sum=0x00180 (speculative carry from bit 8).
- Back-to-back vectors on consecutive cycles → each result appears exactly one cycle later.
- K=0 build, A=0xFFFF, B=0x0001, Cin=0 → Sum=0x10000 (exact). A randomized run must match the reference formula for K=0, 8 and 16.
